// File: rtl/adc_scan_filter_if.sv
// ADC scan filter bus: control, ADC result/channel select, published samples, table read port.
// Latency: none, this file only bundles signals; the master drives enable/adc_result/rd_chan.
// Backpressure: none, samples are one-cycle pulses that the consumer must take when they appear.
interface adc_scan_filter_if;
  logic        enable;
  logic [11:0] adc_result;
  logic [2:0]  chan;
  logic        sample_valid;
  logic [2:0]  sample_chan;
  logic [11:0] sample_data;
  logic        scan_done;
  logic [2:0]  rd_chan;
  logic [11:0] rd_data;

  modport master (
    output enable, adc_result, rd_chan,
    input  chan, sample_valid, sample_chan, sample_data, scan_done, rd_data
  );

  modport slave (
    input  enable, adc_result, rd_chan,
    output chan, sample_valid, sample_chan, sample_data, scan_done, rd_data
  );
endinterface

// File: rtl/adc_scan_filter.sv
// Round-robin ADC scanner: dwell, average 2^AVG_SHIFT samples per channel, publish and store.
// Latency: publish every 2^AVG_SHIFT*(DWELL_CYCLES+1)+1 clocks per channel; table read is combinational.
// Backpressure: none; enable=0 aborts the channel in progress. ADC_SCAN_DEADBAND_EN = change-only publish.
module adc_scan_filter #(
  parameter int NUM_CHAN     = 4,
  parameter int DWELL_CYCLES = 48,
  parameter int AVG_SHIFT    = 2,
  parameter int DEADBAND     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  adc_scan_filter_if.slave  bus
);
  localparam int NSAMP = 1 << AVG_SHIFT;
  localparam int AW    = 12 + AVG_SHIFT;
  localparam int DW    = $clog2(DWELL_CYCLES + 1);
  localparam int SW    = AVG_SHIFT + 1;
  localparam logic [2:0] LAST_CHAN = 3'(NUM_CHAN - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, PUBLISH} state_t;

  state_t        r_state;
  logic [DW-1:0] r_dwell;
  logic [SW-1:0] r_scnt;
  logic [AW-1:0] r_acc;
  logic [2:0]    r_chan;
  logic [2:0]    r_sample_chan;
  logic [11:0]   r_sample_data;
  logic          r_sample_valid;
  logic          r_scan_done;
  logic [11:0]   r_table [NUM_CHAN];

  logic [AW-1:0] w_acc_next;
  logic [11:0]   w_avg;
  logic          w_pub_ok;
  logic [11:0]   w_rd_data;

  // Running sum including the sample being taken this cycle; the average is its truncated top bits.
  assign w_acc_next = r_acc + AW'(bus.adc_result);
  assign w_avg      = 12'(w_acc_next >> AVG_SHIFT);

`ifdef ADC_SCAN_DEADBAND_EN
  logic [NUM_CHAN-1:0] r_seen;
  logic                w_seen;
  logic [11:0]         w_cur;
  logic [11:0]         w_diff;

  // Stored value and first-publish flag of the channel being sampled.
  always_comb begin
    w_seen = 1'b0;
    w_cur  = 12'd0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (r_chan == 3'(i)) begin
        w_seen = r_seen[i];
        w_cur  = r_table[i];
      end
    end
  end

  assign w_diff   = (w_avg > w_cur) ? (w_avg - w_cur) : (w_cur - w_avg);
  assign w_pub_ok = !w_seen || ({20'd0, w_diff} > 32'(DEADBAND));
`else
  logic [31:0] w_unused_deadband;
  assign w_unused_deadband = 32'(DEADBAND);
  assign w_pub_ok          = 1'b1;
`endif

  // Scan sequencer; publish outputs are registered on entry to PUBLISH so they are valid during it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_dwell        <= '0;
      r_scnt         <= '0;
      r_acc          <= '0;
      r_chan         <= 3'd0;
      r_sample_valid <= 1'b0;
      r_sample_chan  <= 3'd0;
      r_sample_data  <= 12'd0;
      r_scan_done    <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_scan_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.enable) begin
            r_state <= SETTLE;
            r_dwell <= '0;
          end
        end
        SETTLE: begin
          if (!bus.enable) begin
            r_state <= IDLE;
            r_dwell <= '0;
            r_scnt  <= '0;
            r_acc   <= '0;
          end else if (r_dwell == DW'(DWELL_CYCLES - 1)) begin
            r_dwell <= '0;
            r_state <= SAMPLE;
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
        SAMPLE: begin
          if (!bus.enable) begin
            r_state <= IDLE;
            r_dwell <= '0;
            r_scnt  <= '0;
            r_acc   <= '0;
          end else begin
            r_acc <= w_acc_next;
            if (r_scnt == SW'(NSAMP - 1)) begin
              r_state        <= PUBLISH;
              r_sample_valid <= w_pub_ok;
              r_sample_chan  <= r_chan;
              r_sample_data  <= w_avg;
              r_scan_done    <= (r_chan == LAST_CHAN);
            end else begin
              r_scnt  <= r_scnt + 1'b1;
              r_state <= SETTLE;
            end
          end
        end
        PUBLISH: begin
          r_acc   <= '0;
          r_scnt  <= '0;
          r_dwell <= '0;
          r_chan  <= (r_chan == LAST_CHAN) ? 3'd0 : r_chan + 3'd1;
          r_state <= bus.enable ? SETTLE : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Value table (and first-publish flags) written at the end of a publishing PUBLISH cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CHAN; i++) r_table[i] <= 12'd0;
`ifdef ADC_SCAN_DEADBAND_EN
      r_seen <= '0;
`endif
    end else if (r_state == PUBLISH && r_sample_valid) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        if (r_sample_chan == 3'(i)) begin
          r_table[i] <= r_sample_data;
`ifdef ADC_SCAN_DEADBAND_EN
          r_seen[i]  <= 1'b1;
`endif
        end
      end
    end
  end

  // Combinational table read; out-of-range addresses read as zero.
  always_comb begin
    w_rd_data = 12'd0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (bus.rd_chan == 3'(i)) w_rd_data = r_table[i];
    end
  end

  assign bus.chan         = r_chan;
  assign bus.sample_valid = r_sample_valid;
  assign bus.sample_chan  = r_sample_chan;
  assign bus.sample_data  = r_sample_data;
  assign bus.scan_done    = r_scan_done;
  assign bus.rd_data      = w_rd_data;
endmodule

// File: tb/tb_adc_scan_filter.sv
// Bench for adc_scan_filter with default parameters: directed channel runs plus a timeline model.
// The model tracks cycles since the start of each channel run and predicts every output each cycle.
// Directed checks pin latency, averaging, wrap, abort, deadband and reset against literal values.
module tb_adc_scan_filter;
  localparam int NCH   = 4;
  localparam int DWELL = 48;
  localparam int NS    = 4;
  localparam int DB    = 8;
  localparam int PUB_T = NS * (DWELL + 1);

  logic clk = 1'b0;
  logic reset_n;
  adc_scan_filter_if bus();

  adc_scan_filter #(.NUM_CHAN(NCH), .DWELL_CYCLES(DWELL), .AVG_SHIFT(2), .DEADBAND(DB)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: m_t counts clocks since the current channel run started.
  bit m_live = 0;
  bit m_run  = 0;
  int m_t    = 0;
  int m_acc  = 0;
  int m_chan = 0;
  int m_tab [NCH];
  bit m_seen [NCH];

  function automatic bit pub_ok(input int c, input int avg);
    int d;
    d = avg - m_tab[c];
    if (d < 0) d = -d;
`ifdef ADC_SCAN_DEADBAND_EN
    return !m_seen[c] || (d > DB);
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_live = 1; m_run = 0; m_t = 0; m_acc = 0; m_chan = 0;
      for (int i = 0; i < NCH; i++) begin m_tab[i] = 0; m_seen[i] = 0; end
    end else if (m_live) begin
      if (!m_run) begin
        if (bus.enable) begin m_run = 1; m_t = 0; m_acc = 0; end
      end else if (m_t == PUB_T) begin
        if (pub_ok(m_chan, m_acc / NS)) begin
          m_tab[m_chan] = m_acc / NS;
          m_seen[m_chan] = 1;
        end
        m_chan = (m_chan + 1) % NCH;
        m_acc = 0; m_t = 0;
        m_run = bus.enable;
      end else if (!bus.enable) begin
        m_run = 0; m_acc = 0;
      end else begin
        if (m_t % (DWELL + 1) == DWELL) m_acc += int'(bus.adc_result);
        m_t++;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      bit pub, ok;
      int exp_rd;
      pub = m_run && (m_t == PUB_T);
      ok  = pub && pub_ok(m_chan, m_acc / NS);
      chk("m_sample_valid", bus.sample_valid, ok);
      if (ok) begin
        chk("m_sample_chan", bus.sample_chan, m_chan);
        chk("m_sample_data", bus.sample_data, m_acc / NS);
      end
      chk("m_scan_done", bus.scan_done, pub && (m_chan == NCH - 1));
      chk("m_chan", bus.chan, m_chan);
      exp_rd = (bus.rd_chan < NCH) ? m_tab[bus.rd_chan] : 0;
      chk("m_rd_data", bus.rd_data, exp_rd);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one channel run from its first SETTLE cycle; returns in its PUBLISH cycle.
  task automatic run_chan(input logic [11:0] v0, input logic [11:0] v1,
                          input logic [11:0] v2, input logic [11:0] v3);
    logic [11:0] v [4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int k = 0; k < 4; k++) begin
      bus.adc_result = v[k];
      tick(DWELL + 1);
    end
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [11:0] exp);
    bus.rd_chan = a;
    #1;
    chk(name, bus.rd_data, exp);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.enable = 1'b0;
    bus.adc_result = 12'd0;
    bus.rd_chan = 3'd0;
    tick(3);
    reset_n = 1'b1;
    chk("rst_chan", bus.chan, 0);
    chk("rst_valid", bus.sample_valid, 0);
    for (int i = 0; i < NCH; i++) begin
      rd_check("rst_rd", 3'(i), 12'd0);
      tick(1);
    end
    bus.rd_chan = 3'd0;

    // Latency: first SETTLE cycle is cycle 0, publish in cycle 196, next in 393.
    bus.adc_result = 12'hABC;
    bus.enable = 1'b1;
    tick(1);
    tick(195);
    chk("lat_no_valid_195", bus.sample_valid, 0);
    tick(1);
    chk("lat_valid_196", bus.sample_valid, 1);
    chk("lat_chan_196", bus.sample_chan, 0);
    chk("lat_data_196", bus.sample_data, 12'hABC);
    tick(1);
    run_chan(12'hABC, 12'hABC, 12'hABC, 12'hABC);
    chk("lat_valid_393", bus.sample_valid, 1);
    chk("lat_chan_393", bus.sample_chan, 1);
    tick(1);

    // Abort on chan 2 at SETTLE cycle 30, then restart on the same channel.
    tick(30);
    bus.enable = 1'b0;
    tick(1);
    chk("abort_chan", bus.chan, 2);
    chk("abort_valid", bus.sample_valid, 0);
    tick(5);
    chk("abort_chan_hold", bus.chan, 2);
    bus.enable = 1'b1;
    tick(1);
    run_chan(12'd200, 12'd200, 12'd200, 12'd200);
    chk("restart_valid", bus.sample_valid, 1);
    chk("restart_chan", bus.sample_chan, 2);
    chk("restart_data", bus.sample_data, 200);
    tick(1);

    // Wrap: channel 3 publishes with scan_done, then chan returns to 0.
    run_chan(12'd7, 12'd7, 12'd7, 12'd7);
    chk("wrap_done", bus.scan_done, 1);
    chk("wrap_chan3", bus.sample_chan, 3);
    tick(1);
    chk("wrap_chan0", bus.chan, 0);
    chk("wrap_no_valid", bus.sample_valid, 0);

    // Averaging with truncation: 407 >> 2 = 101.
    run_chan(12'd100, 12'd101, 12'd102, 12'd104);
    chk("avg_data", bus.sample_data, 101);
    chk("avg_done_clear", bus.scan_done, 0);
    tick(1);
    rd_check("avg_rd0", 3'd0, 12'd101);
    rd_check("rd_out_of_range", 3'd5, 12'd0);
    bus.rd_chan = 3'd0;

    // Deadband: table[1] = 100, then 105 (within band), then 109 (outside band).
    run_chan(12'd100, 12'd100, 12'd100, 12'd100);
    chk("db_seed_valid", bus.sample_valid, 1);
    tick(1);
    run_chan(12'd50, 12'd50, 12'd50, 12'd50);   tick(1);
    run_chan(12'd60, 12'd60, 12'd60, 12'd60);   tick(1);
    run_chan(12'd70, 12'd70, 12'd70, 12'd70);   tick(1);
    run_chan(12'd105, 12'd105, 12'd105, 12'd105);
`ifdef ADC_SCAN_DEADBAND_EN
    chk("db_105_valid", bus.sample_valid, 0);
    tick(1);
    rd_check("db_105_rd", 3'd1, 12'd100);
`else
    chk("db_105_valid", bus.sample_valid, 1);
    tick(1);
    rd_check("db_105_rd", 3'd1, 12'd105);
`endif
    bus.rd_chan = 3'd0;
    run_chan(12'd51, 12'd51, 12'd51, 12'd51);   tick(1);
    run_chan(12'd61, 12'd61, 12'd61, 12'd61);
    chk("db_done_ch3", bus.scan_done, 1);
    tick(1);
    run_chan(12'd71, 12'd71, 12'd71, 12'd71);   tick(1);
    run_chan(12'd109, 12'd109, 12'd109, 12'd109);
    chk("db_109_valid", bus.sample_valid, 1);
    tick(1);
    rd_check("db_109_rd", 3'd1, 12'd109);
    bus.rd_chan = 3'd0;

    // Reset held 3 cycles mid-SETTLE on chan 2 clears everything.
    tick(20);
    chk("pre_rst_chan", bus.chan, 2);
    reset_n = 1'b0;
    tick(3);
    chk("rst2_chan", bus.chan, 0);
    chk("rst2_valid", bus.sample_valid, 0);
    reset_n = 1'b1;
    bus.enable = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      rd_check("rst2_rd", 3'(i), 12'd0);
      tick(1);
    end
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adc_scan_filter.md
ADC_SCAN_FILTER -- requirements
Module: adc_scan_filter

Interface
REQ-001 SHALL have parameter NUM_CHAN, default 4: number of channels scanned, 0..NUM_CHAN-1, legal 1..8.
REQ-002 SHALL have parameter DWELL_CYCLES, default 48: clocks waited before each sample; must be at least 2 ADC conversion periods.
REQ-003 SHALL have parameter AVG_SHIFT, default 2: 2^AVG_SHIFT samples averaged per channel, legal 0..4.
REQ-004 SHALL have parameter DEADBAND, default 8: change threshold, used only under REQ-027.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 enable  input  1  high = scanning runs; low = scanning stops (REQ-020).
REQ-008 adc_result  input  12  latest unsigned conversion result from the ADC interface.
REQ-009 chan  output  3  channel requested from the ADC interface; registered.
REQ-010 sample_valid  output  1  one-cycle pulse when a channel average is published.
REQ-011 sample_chan  output  3  channel of the published average; meaningful only while sample_valid=1.
REQ-012 sample_data  output  12  published average; meaningful only while sample_valid=1.
REQ-013 scan_done  output  1  one-cycle pulse, coincident with the publish of channel NUM_CHAN-1.
REQ-014 rd_chan  input  3  read address into the per-channel value table.
REQ-015 rd_data  output  12  stored average for rd_chan; combinational read; rd_chan>=NUM_CHAN returns 0.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, SAMPLE and PUBLISH; reset state is IDLE.
- IDLE: enable=1 -> SETTLE, with dwell counter cleared.
- SETTLE: counts DWELL_CYCLES clocks, 0..DWELL_CYCLES-1; at the terminal count -> SAMPLE.
- SAMPLE: one cycle; acc += adc_result; sample count +1. If this is the 2^AVG_SHIFT-th sample -> PUBLISH, else -> SETTLE.
- PUBLISH: one cycle, actions per REQ-017..019; then -> SETTLE if enable=1, else -> IDLE.
REQ-017 Accumulator SHALL be 12+AVG_SHIFT bits wide, unsigned, no saturation; average = acc >> AVG_SHIFT, truncated.
REQ-018 In PUBLISH, the block SHALL drive sample_valid=1, sample_chan=chan and sample_data=average, and SHALL write the average into table[chan].
REQ-019 In PUBLISH, the block SHALL clear acc and the sample count, and SHALL advance chan; chan NUM_CHAN-1 wraps to 0 with scan_done=1 in the same cycle.
REQ-020 enable=0 in SETTLE or SAMPLE SHALL force IDLE next cycle.
- acc, sample count and dwell counter are discarded; no publish occurs.
- chan is retained; a restart runs a full dwell/sample sequence on that same channel.
REQ-021 chan SHALL change only in PUBLISH or on reset, so the ADC pipeline settles for DWELL_CYCLES before every sample.
REQ-022 NUM_CHAN=1 SHALL keep chan=0 permanently, with scan_done pulsing on every publish.
REQ-023 Per-channel publish period SHALL be exactly 2^AVG_SHIFT*(DWELL_CYCLES+1)+1 clocks under continuous enable; 197 for the defaults.

Reset
REQ-024 reset_n=0 at a clock edge SHALL set:
- state = IDLE; chan = 0; acc and all counters = 0;
- sample_valid = 0, scan_done = 0, sample_chan = 0, sample_data = 0;
- every table entry = 0.
REQ-025 Reset SHALL override enable and any in-progress state, including PUBLISH; a publish coinciding with reset is lost.

Configuration
REQ-026 Macro ADC_SCAN_DEADBAND_EN SHALL select change-only publishing.
REQ-027 With ADC_SCAN_DEADBAND_EN defined:
- PUBLISH writes the table and pulses sample_valid only if |average - table[chan]| > DEADBAND, or the channel has never published since reset (per-channel seen bit, cleared by reset).
- Otherwise nothing is written and sample_valid stays 0.
- chan advance and scan_done are unaffected.
REQ-028 Without ADC_SCAN_DEADBAND_EN, every PUBLISH writes the table and pulses sample_valid (REQ-018); no seen bits or comparator are built.

Verification (NUM_CHAN=4, DWELL_CYCLES=48, AVG_SHIFT=2)
REQ-029 Reset: reset_n=0 for 3 cycles mid-SETTLE on chan 2 -> chan=0, sample_valid=0, rd_data=0 for rd_chan 0..3.
REQ-030 Latency: adc_result=12'hABC, enable=1, first SETTLE cycle = cycle 0 -> sample_valid=1 only at cycle 196, sample_chan=0, sample_data=12'hABC; next publish at cycle 393 with sample_chan=1.
REQ-031 Averaging: samples 100, 101, 102, 104 -> sample_data=101 (407>>2); rd_chan=0 then reads 101.
REQ-032 Wrap: channel 3 publishes -> scan_done=1 in the same cycle, chan=0 next cycle, no sample_valid for channel 4.
REQ-033 Abort: enable=0 at cycle 30 of SETTLE on chan 2 -> IDLE next cycle, no pulse, chan stays 2; re-enable -> publish for chan 2 after 197 clocks.
REQ-034 Deadband (macro on): table[1]=100; average 105 -> no sample_valid, rd_data stays 100; average 109 -> sample_valid=1, rd_data=109. Macro off: average 105 publishes.
